// File: rtl/cr_structs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_structs : shared AXI4-Stream datapath types and arbiter state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package cr_structs;

    localparam int AXI4S_DATA_W = 64;
    localparam int AXI4S_STRB_W = AXI4S_DATA_W / 8;
    localparam int AXI4S_ID_W   = 4;
    localparam int AXI4S_USER_W = 8;

    typedef struct packed {
        logic                    tvalid;
        logic                    tlast;
        logic [AXI4S_ID_W-1:0]   tid;
        logic [AXI4S_USER_W-1:0] tuser;
        logic [AXI4S_STRB_W-1:0] tstrb;
        logic [AXI4S_DATA_W-1:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/cr_axi4s_pkt_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_axi4s_pkt_arb_if : source FIFO heads, pops and outbound beat of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface cr_axi4s_pkt_arb_if #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
);
    import cr_structs::*;

    logic [N_SRC-1:0] src_en;
    axi4s_dp_bus_t    axi4s_in [N_SRC];
    logic [N_SRC-1:0] axi4s_in_empty;
    logic [N_SRC-1:0] axi4s_src_rd;
    axi4s_dp_rdy_t    axi4s_ob_in;
    axi4s_dp_bus_t    axi4s_ob_out;
    logic [SRC_W-1:0] cur_grant;
    logic             busy;
    logic             pkt_done;

    modport master (
        input  src_en, axi4s_in, axi4s_in_empty, axi4s_ob_in,
        output axi4s_src_rd, axi4s_ob_out, cur_grant, busy, pkt_done
    );

    modport slave (
        output src_en, axi4s_in, axi4s_in_empty, axi4s_ob_in,
        input  axi4s_src_rd, axi4s_ob_out, cur_grant, busy, pkt_done
    );

endinterface
`default_nettype wire

// File: rtl/cr_axi4s_pkt_arb_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_rr_pick : combinational round-robin pick, first set req bit from ptr up
// Rev 1.0
// ---------------------------------------------------------------------------
module cr_rr_pick #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  wire logic [N_SRC-1:0] req,
    input  wire logic [SRC_W-1:0] ptr,
    output logic      [SRC_W-1:0] gnt_idx,
    output logic                  gnt_vld
);

    logic [SRC_W:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_sum   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr} + (SRC_W + 1)'(i);
            if (w_sum >= (SRC_W + 1)'(N_SRC)) begin
                w_sum = w_sum - (SRC_W + 1)'(N_SRC);
            end
            if ((w_sum < (SRC_W + 1)'(N_SRC)) && req[w_sum[SRC_W-1:0]]) begin
                gnt_idx = w_sum[SRC_W-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cr_axi4s_pkt_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cr_axi4s_pkt_arb : packet-atomic round-robin arbiter over N_SRC AXI4-S FIFOs
// Rev 1.0
// ---------------------------------------------------------------------------
module cr_axi4s_pkt_arb
    import cr_structs::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cr_axi4s_pkt_arb_if.master  bus
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] r_cur_grant;
    axi4s_dp_bus_t    r_ob;
    logic             r_pkt_done;

    logic [N_SRC-1:0] w_req;
    logic [SRC_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic             w_ld;
    logic             w_pop;
    logic [N_SRC-1:0] w_src_rd;
    axi4s_dp_bus_t    w_head;
    logic [SRC_W-1:0] w_ptr_inc;
    logic             w_tready;

    assign w_tready  = bus.axi4s_ob_in.tready;
    assign w_req     = bus.src_en & ~bus.axi4s_in_empty;
    assign w_ld      = ~r_ob.tvalid | w_tready;
    assign w_head    = bus.axi4s_in[r_cur_grant];
    assign w_ptr_inc = (r_cur_grant == SRC_W'(N_SRC - 1)) ? '0 : r_cur_grant + 1'b1;

    cr_rr_pick #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .req     (w_req),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only XFER pops; the grant is held until the tlast beat leaves the FIFO.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_src_rd    = '0;
        case (r_state)
            ARB: begin
                if (w_gnt_vld) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                w_pop                 = ~bus.axi4s_in_empty[r_cur_grant] & w_ld;
                w_src_rd[r_cur_grant] = w_pop;
                if (w_pop && w_head.tlast) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_cur_grant <= '0;
            r_ob        <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= r_ob.tvalid & r_ob.tlast & w_tready;
            if ((r_state == ARB) && w_gnt_vld) begin
                r_cur_grant <= w_gnt_idx;
            end
            // Source tvalid is ignored: FIFO non-empty is the validity indication.
            if (w_pop) begin
                r_ob        <= w_head;
                r_ob.tvalid <= 1'b1;
            end else if (r_ob.tvalid && w_tready) begin
                r_ob.tvalid <= 1'b0;
            end
            if (w_pop && w_head.tlast) begin
                r_rr_ptr <= w_ptr_inc;
            end
        end
    end

    assign bus.axi4s_src_rd = w_src_rd;
    assign bus.axi4s_ob_out = r_ob;
    assign bus.cur_grant    = r_cur_grant;
    assign bus.busy         = (r_state == XFER);
    assign bus.pkt_done     = r_pkt_done;

endmodule
`default_nettype wire
